// File: rtl/srm_pkg.sv
// Shared definitions for the operand-fetch stage and the later datapath stages:
// widths, shifter/ALU encodings and the fetch FSM state type.
package srm_pkg;

   localparam int DW     = 16;
   localparam int NREG   = 8;
   localparam int REG_AW = $clog2(NREG);

   typedef enum logic [1:0] {
      SH_NONE = 2'b00,
      SH_LSL  = 2'b01,
      SH_LSR  = 2'b10,
      SH_ASR  = 2'b11
   } shift_e;

   typedef enum logic [1:0] {
      ADD = 2'b00,
      SUB = 2'b01,
      AND = 2'b10,
      NOT = 2'b11
   } aluop_e;

   typedef enum logic [1:0] {
      IDLE,
      READ_A,
      READ_B,
      ISSUE
   } opf_state_e;

endpackage

// File: rtl/operand_shifter.sv
// One-bit B-operand shifter: none / shift-left / logical-right / arithmetic-right.
// Purely combinational so later stages can reuse it.
module operand_shifter
   import srm_pkg::*;
#(
   parameter int DW = srm_pkg::DW
) (
   input  logic [DW-1:0] data_i,
   input  logic [1:0]    shift_i,
   output logic [DW-1:0] data_o
);

   always_comb begin
      // NOTE: default assignment first so every path drives data_o and no latch is inferred.
      data_o = data_i;
      case (shift_i)
         SH_NONE: data_o = data_i;
         SH_LSL:  data_o = {data_i[DW-2:0], 1'b0};
         SH_LSR:  data_o = {1'b0, data_i[DW-1:1]};
         SH_ASR:  data_o = {data_i[DW-1], data_i[DW-1:1]};
         default: data_o = data_i;
      endcase
   end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: register file, single shared read port, 4-state fetch FSM and
// registered Ain/Bin/ALUop. Define OPFETCH_BYPASS_EN to forward same-cycle writeback data.
module operand_fetch
   import srm_pkg::*;
#(
   parameter  int DW   = srm_pkg::DW,
   parameter  int NREG = srm_pkg::NREG,
   localparam int AW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [AW-1:0] req_rn,
   input  logic [AW-1:0] req_rm,
   input  logic [1:0]    req_shift,
   input  logic [1:0]    req_aluop,
   input  logic          req_asel,
   input  logic          req_bsel,
   input  logic [DW-1:0] req_imm,
   input  logic          wb_en,
   input  logic [AW-1:0] wb_addr,
   input  logic [DW-1:0] wb_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] Ain,
   output logic [DW-1:0] Bin,
   output logic [1:0]    ALUop
);

   opf_state_e    state_q, state_d;
   logic          accept;

   logic [AW-1:0] rn_q, rm_q;
   logic [1:0]    shift_q, op_q;
   logic          asel_q, bsel_q;
   logic [DW-1:0] imm_q;

   logic [DW-1:0] rf_q [NREG];
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic [DW-1:0] shifted;

   logic [DW-1:0] ain_q, bin_q;
   logic [1:0]    aluop_q;

   assign accept = req_valid && req_ready;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid) state_d = READ_A;
         READ_A:  state_d = READ_B;
         READ_B:  state_d = ISSUE;
         ISSUE:   if (out_ready) state_d = req_valid ? READ_A : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state_q == IDLE) || (state_q == ISSUE && out_ready);
      out_valid = (state_q == ISSUE);
   end

   // ---------------- request capture ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rn_q    <= '0;
         rm_q    <= '0;
         shift_q <= '0;
         op_q    <= '0;
         asel_q  <= 1'b0;
         bsel_q  <= 1'b0;
         imm_q   <= '0;
      end else if (accept) begin
         rn_q    <= req_rn;
         rm_q    <= req_rm;
         shift_q <= req_shift;
         op_q    <= req_aluop;
         asel_q  <= req_asel;
         bsel_q  <= req_bsel;
         imm_q   <= req_imm;
      end
   end

   // ---------------- register file ----------------
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: the register file must read as zero after reset, so it is built from resettable flops rather than a RAM macro.
      if (reset) begin
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else if (wb_en) begin
         rf_q[wb_addr] <= wb_data;
      end
   end

   assign rd_addr = (state_q == READ_B) ? rm_q : rn_q;

`ifdef OPFETCH_BYPASS_EN
   assign rd_data = (wb_en && wb_addr == rd_addr) ? wb_data : rf_q[rd_addr];
`else
   assign rd_data = rf_q[rd_addr];
`endif

   operand_shifter #(.DW(DW)) u_shifter (
      .data_i  (rd_data),
      .shift_i (shift_q),
      .data_o  (shifted)
   );

   // ---------------- operand registers ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ain_q   <= '0;
         bin_q   <= '0;
         aluop_q <= '0;
      end else begin
         case (state_q)
            READ_A: ain_q <= asel_q ? '0 : rd_data;
            READ_B: begin
               bin_q   <= bsel_q ? imm_q : shifted;
               aluop_q <= op_q;
            end
            default: ;
         endcase
      end
   end

   assign Ain   = ain_q;
   assign Bin   = bin_q;
   assign ALUop = aluop_q;

endmodule
